// File: rtl/ring_div_pkg.sv
// Shared constants and FSM state type for the ring-oscillator divider/meter blocks.
package ring_div_pkg;

   localparam int unsigned N_TAPS        = 7;
   localparam int unsigned SYNC_STAGES   = 2;
   localparam int unsigned SETTLE_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      GATE,
      DONE
   } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit clock-domain-crossing synchronizer, resets to 0.
module sync_2ff
   import ring_div_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stg_d;
   logic [SYNC_STAGES-1:0] stg_q;

   // Shift the asynchronous input through the synchronizer chain.
   always_comb begin
      stg_d = {stg_q[SYNC_STAGES-2:0], d};
   end

   // Synchronizer flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_q <= '0;
      end else begin
         stg_q <= stg_d;
      end
   end

   assign q = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/ring_freq_meter.sv
// Counts rising edges of one synchronized divided ring-oscillator clock over a
// fixed window of system clocks and publishes the (saturating) result.
module ring_freq_meter
   import ring_div_pkg::*;
#(
   parameter int unsigned N_TAPS      = ring_div_pkg::N_TAPS,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned GATE_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_TAPS-1:0] div_clks,
   input  logic [2:0]        sel,
   input  logic              start,
   output logic              busy,
   output logic              valid,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   // One timer serves both the settle and gate phases.
   localparam int unsigned TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   logic [N_TAPS-1:0] sync_bus;
   logic              sync_sel;
   logic              rise;

   state_e            state_d, state_q;
   logic [2:0]        sel_d, sel_q;
   logic              busy_d, busy_q;
   logic              valid_d, valid_q;
   logic [TMR_W-1:0]  timer_d, timer_q;
   logic [CNT_W-1:0]  edge_cnt_d, edge_cnt_q;
   logic              ovf_d, ovf_q;
   logic [CNT_W-1:0]  count_d, count_q;
   logic              overflow_d, overflow_q;
   logic              prev_q;

   for (genvar i = 0; i < N_TAPS; i++) begin : g_sync
      sync_2ff u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (div_clks[i]),
         .q     (sync_bus[i])
      );
   end

   // Tap mux on the synchronized bus; out-of-range selects read as constant 0.
   always_comb begin
      sync_sel = 1'b0;
      if (32'(sel_q) < N_TAPS) begin
         sync_sel = sync_bus[sel_q];
      end
      rise = sync_sel & ~prev_q;
   end

   // Measurement FSM, gate timer and saturating edge counter.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      timer_d    = timer_q;
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sel_d      = sel;
               busy_d     = 1'b1;
               edge_cnt_d = '0;
               ovf_d      = 1'b0;
               timer_d    = SETTLE_LOAD;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            // prev_q catches up with the newly selected tap here, so no false edge.
            if (timer_q == '0) begin
               timer_d = GATE_LOAD;
               state_d = GATE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         GATE: begin
            if (rise) begin
               if (edge_cnt_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  edge_cnt_d = edge_cnt_q + CNT_W'(1);
               end
            end
            if (timer_q == '0) begin
               state_d = DONE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         DONE: begin
            count_d    = edge_cnt_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         timer_q    <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         prev_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         timer_q    <= timer_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         prev_q     <= sync_sel;
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a full-width and a 4-bit (saturating) instance run in lockstep.
module tb_ring_freq_meter;

   localparam int unsigned GC  = 256;
   localparam int          LAT = GC + 3;

   typedef struct packed {
      logic [15:0] cnt;
      logic        ovf;
   } res_t;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic [6:0]  div_clks = '0;
   logic [2:0]  sel      = '0;
   logic        start    = 1'b0;
   logic        busy, valid, overflow;
   logic [15:0] count;
   logic        busy_s, valid_s, overflow_s;
   logic [3:0]  count_s;

   int          passed = 0;
   int          total  = 0;
   res_t        exp_q[$];
   res_t        exp_s_q[$];
   int unsigned phase  = 0;

   ring_freq_meter #(.N_TAPS(7), .CNT_W(16), .GATE_CYCLES(GC)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .div_clks (div_clks),
      .sel      (sel),
      .start    (start),
      .busy     (busy),
      .valid    (valid),
      .count    (count),
      .overflow (overflow)
   );

   ring_freq_meter #(.N_TAPS(7), .CNT_W(4), .GATE_CYCLES(GC)) u_dut_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .div_clks (div_clks),
      .sel      (sel),
      .start    (start),
      .busy     (busy_s),
      .valid    (valid_s),
      .count    (count_s),
      .overflow (overflow_s)
   );

   always #5 clk = ~clk;

   // Ripple-divider stand-in: bit i has period 2^(i+1) clks, changing on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         phase++;
         div_clks = phase[6:0];
      end
   end

   // Expected result for a window of GC clks on tap s with a cnt_w-bit counter.
   function automatic res_t model(input logic [2:0] s, input int unsigned cnt_w);
      int unsigned edges;
      int unsigned maxv;
      res_t r;
      edges = (s < 3'd7) ? (GC >> (int'(s) + 1)) : 0;
      maxv  = (1 << cnt_w) - 1;
      r.cnt = 16'((edges > maxv) ? maxv : edges);
      r.ovf = (edges > maxv);
      return r;
   endfunction

   // Pulse start for one sampling edge and record the expected results.
   task automatic kick(input logic [2:0] s);
      @(negedge clk);
      sel   = s;
      start = 1'b1;
      exp_q.push_back(model(s, 16));
      exp_s_q.push_back(model(s, 4));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for valid; lat counts edges after the start-sampling edge.
   task automatic wait_valid(output int lat, output int busy_gaps);
      lat       = -1;
      busy_gaps = 0;
      for (int k = 1; k <= LAT + 40; k++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) begin
            lat = k;
            break;
         end
         if (busy !== 1'b1) busy_gaps++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
      total++; if (count !== 16'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
      total++;
      if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passed++;
      total++;
      if (count_s !== 4'd0) $display("FAIL reset_count_sat: got %0d want 0", count_s); else passed++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_exact();
      int   lat, gaps;
      res_t e, es;
      kick(3'd2);
      total++; if (busy !== 1'b1) $display("FAIL exact_busy_on: got %b want 1", busy); else passed++;
      wait_valid(lat, gaps);
      e  = exp_q.pop_front();
      es = exp_s_q.pop_front();
      total++; if (lat !== LAT) $display("FAIL exact_latency: got %0d want %0d", lat, LAT); else passed++;
      total++; if (gaps !== 0) $display("FAIL exact_busy_gaps: got %0d want 0", gaps); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL exact_busy_off: got %b want 0", busy); else passed++;
      total++; if (count !== e.cnt) $display("FAIL exact_count: got %0d want %0d", count, e.cnt); else passed++;
      total++;
      if (overflow !== e.ovf) $display("FAIL exact_ovf: got %b want %b", overflow, e.ovf); else passed++;
      total++;
      if (count_s !== es.cnt[3:0]) $display("FAIL exact_count_sat: got %0d want %0d", count_s, es.cnt);
      else passed++;
      @(posedge clk);
      #1;
      total++; if (valid !== 1'b0) $display("FAIL exact_valid_pulse: got %b want 0", valid); else passed++;
      total++; if (count !== e.cnt) $display("FAIL exact_count_hold: got %0d want %0d", count, e.cnt); else passed++;
   endtask

   task automatic test_tap_sel();
      int   lat, gaps;
      res_t e, es;
      for (int t = 0; t < 2; t++) begin
         kick((t == 0) ? 3'd0 : 3'd7);
         wait_valid(lat, gaps);
         e  = exp_q.pop_front();
         es = exp_s_q.pop_front();
         total++; if (lat !== LAT) $display("FAIL tap_latency: got %0d want %0d", lat, LAT); else passed++;
         total++;
         if (count !== e.cnt) $display("FAIL tap_count: got %0d want %0d", count, e.cnt); else passed++;
         total++;
         if (overflow !== e.ovf) $display("FAIL tap_ovf: got %b want %b", overflow, e.ovf); else passed++;
         total++;
         if (overflow_s !== es.ovf) $display("FAIL tap_ovf_sat: got %b want %b", overflow_s, es.ovf);
         else passed++;
      end
   endtask

   task automatic test_saturation();
      int   lat, gaps;
      res_t e, es;
      for (int t = 0; t < 2; t++) begin
         kick((t == 0) ? 3'd1 : 3'd7);
         wait_valid(lat, gaps);
         e  = exp_q.pop_front();
         es = exp_s_q.pop_front();
         total++;
         if (valid_s !== 1'b1) $display("FAIL sat_valid: got %b want 1", valid_s); else passed++;
         total++;
         if (count_s !== es.cnt[3:0]) $display("FAIL sat_count: got %0d want %0d", count_s, es.cnt);
         else passed++;
         total++;
         if (overflow_s !== es.ovf) $display("FAIL sat_ovf: got %b want %b", overflow_s, es.ovf);
         else passed++;
         total++;
         if (count !== e.cnt) $display("FAIL sat_wide_count: got %0d want %0d", count, e.cnt); else passed++;
      end
   endtask

   task automatic test_ignored();
      int   lat    = -1;
      int   nvalid = 0;
      int   extra  = 0;
      res_t e;
      kick(3'd2);
      // k counts edges after the start-sampling edge; GATE begins at k = 2.
      for (int k = 1; k <= LAT + 40; k++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) begin
            nvalid++;
            if (lat < 0) begin
               lat = k;
               e   = exp_q.pop_front();
               void'(exp_s_q.pop_front());
               total++;
               if (count !== e.cnt) $display("FAIL ign_count: got %0d want %0d", count, e.cnt);
               else passed++;
            end
         end else if (lat > 0 && busy === 1'b1) begin
            extra++;
         end
         if (k == 11) begin
            start = 1'b1;
            sel   = 3'd0;
         end
         if (k == 12) start = 1'b0;
         if (k == 100) sel = 3'd5;
      end
      total++; if (lat !== LAT) $display("FAIL ign_latency: got %0d want %0d", lat, LAT); else passed++;
      total++; if (nvalid !== 1) $display("FAIL ign_valid_count: got %0d want 1", nvalid); else passed++;
      total++; if (extra !== 0) $display("FAIL ign_second_busy: got %0d want 0", extra); else passed++;
   endtask

   task automatic test_back_to_back();
      int   lat, gaps;
      res_t e;
      kick(3'd2);
      wait_valid(lat, gaps);
      e = exp_q.pop_front();
      void'(exp_s_q.pop_front());
      total++; if (count !== e.cnt) $display("FAIL b2b_first_count: got %0d want %0d", count, e.cnt); else passed++;
      // Still inside the valid cycle: this start is sampled by the next edge.
      start = 1'b1;
      sel   = 3'd2;
      exp_q.push_back(model(3'd2, 16));
      exp_s_q.push_back(model(3'd2, 4));
      @(posedge clk);
      #1;
      start = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL b2b_busy_restart: got %b want 1", busy); else passed++;
      total++; if (valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", valid); else passed++;
      wait_valid(lat, gaps);
      e = exp_q.pop_front();
      void'(exp_s_q.pop_front());
      total++; if (lat !== LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); else passed++;
      total++; if (gaps !== 0) $display("FAIL b2b_busy_gaps: got %0d want 0", gaps); else passed++;
      total++; if (count !== e.cnt) $display("FAIL b2b_second_count: got %0d want %0d", count, e.cnt); else passed++;
   endtask

   task automatic test_reset_mid();
      int nvalid = 0;
      int nbusy  = 0;
      kick(3'd1);
      // kick returns one edge after sampling; 101 more edges puts us ~100 cycles into GATE.
      repeat (101) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
      total++; if (valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", valid); else passed++;
      total++; if (count !== 16'd0) $display("FAIL rst_mid_count: got %0d want 0", count); else passed++;
      total++;
      if (overflow_s !== 1'b0) $display("FAIL rst_mid_ovf_sat: got %b want 0", overflow_s); else passed++;
      #3 rst_n = 1'b1;
      exp_q.delete();
      exp_s_q.delete();
      for (int k = 0; k < LAT + 40; k++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1 || valid_s === 1'b1) nvalid++;
         if (busy === 1'b1) nbusy++;
      end
      total++; if (nvalid !== 0) $display("FAIL rst_mid_no_valid: got %0d want 0", nvalid); else passed++;
      total++; if (nbusy !== 0) $display("FAIL rst_mid_no_busy: got %0d want 0", nbusy); else passed++;
   endtask

   initial begin
      test_reset();
      test_exact();
      test_tap_sel();
      test_saturation();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
